// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle for the frame-buffer arbiter: display read port, video-input
// write port, SRAM pad side, and debug visibility of the arbiter state.
//
// Handshake: RD_REQ/WR_REQ act as valid and RD_ACK/WR_ACK act as ready. A
// transfer happens on a rising edge where REQ & ACK are both high. The
// requester holds REQ, ADDR and DATA stable until that edge. ACK may depend
// combinationally on REQ. REQ must not depend on ACK within the same cycle.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WR_MAX_WAIT = 8
);
  localparam int CNT_W = $clog2(WR_MAX_WAIT + 1);

  // display read port
  logic              RD_REQ;
  logic [ADDR_W-1:0] RD_ADDR;
  logic              RD_ACK;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;

  // video-input write port
  logic              WR_REQ;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_ACK;
  logic              WR_URGENT;

  // SRAM pads
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_CE_N;
  logic              MEM_OE_N;
  logic              MEM_WE_N;

  // debug: bus direction this cycle (0 none, 1 read, 2 write) and write wait count
  logic [1:0]        DBG_LAST_OP;
  logic [CNT_W-1:0]  DBG_WAIT_CNT;

  // arbiter side
  modport slave (
    input  RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA, MEM_RDATA,
    output RD_ACK, RD_DATA, RD_VALID, WR_ACK, WR_URGENT,
    output MEM_ADDR, MEM_WDATA, MEM_CE_N, MEM_OE_N, MEM_WE_N,
    output DBG_LAST_OP, DBG_WAIT_CNT
  );

  // requesters plus SRAM model side
  modport master (
    output RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA, MEM_RDATA,
    input  RD_ACK, RD_DATA, RD_VALID, WR_ACK, WR_URGENT,
    input  MEM_ADDR, MEM_WDATA, MEM_CE_N, MEM_OE_N, MEM_WE_N,
    input  DBG_LAST_OP, DBG_WAIT_CNT
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer SRAM arbiter. Display reads take priority. A write
// that has been refused WR_MAX_WAIT times becomes urgent and wins next. Every
// change of bus direction costs one idle cycle so the SRAM data pins can turn
// around. All SRAM controls are registered.
module vga_fb_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WR_MAX_WAIT = 8
) (
  input logic             CLK,
  input logic             NRST,
  vga_fb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(WR_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WR_MAX_WAIT);

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_e;

  op_e               last_op_q, last_op_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  op_e  cand;
  logic grant_ok;
  logic rd_xfer;
  logic wr_xfer;
  logic wr_urgent;

  assign wr_urgent = (wait_cnt_q == WAIT_MAX);

  // Pick this cycle's candidate and decide whether it can go without a bubble
  always_comb begin
    cand = OP_NONE;
    if (wr_urgent && bus.WR_REQ) begin
      cand = OP_WR;
    end else if (bus.RD_REQ) begin
      cand = OP_RD;
    end else if (bus.WR_REQ) begin
      cand = OP_WR;
    end
    // a direction change must pass through an idle bus cycle first
    grant_ok = (cand != OP_NONE) && ((last_op_q == OP_NONE) || (last_op_q == cand));
    // acks are held low while reset is asserted, even before the first edge
    rd_xfer  = NRST && grant_ok && (cand == OP_RD);
    wr_xfer  = NRST && grant_ok && (cand == OP_WR);
  end

  // Next bus cycle contents, read-data capture and write wait counter
  always_comb begin
    last_op_d   = OP_NONE;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rd_xfer) begin
      last_op_d  = OP_RD;
      ce_n_d     = 1'b0;
      oe_n_d     = 1'b0;
      mem_addr_d = bus.RD_ADDR;
    end else if (wr_xfer) begin
      last_op_d   = OP_WR;
      ce_n_d      = 1'b0;
      we_n_d      = 1'b0;
      mem_addr_d  = bus.WR_ADDR;
      mem_wdata_d = bus.WR_DATA;
    end

    // the SRAM drives data during a read bus cycle; capture it at that cycle's end
    rd_valid_d = (last_op_q == OP_RD);
    rd_data_d  = rd_valid_d ? bus.MEM_RDATA : rd_data_q;

    wait_cnt_d = wait_cnt_q;
    if (!bus.WR_REQ || wr_xfer) begin
      wait_cnt_d = '0;
    end else if (!wr_urgent) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Register bus direction, SRAM controls, read data and wait counter
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      last_op_q   <= OP_NONE;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      last_op_q   <= last_op_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign bus.RD_ACK       = rd_xfer;
  assign bus.WR_ACK       = wr_xfer;
  assign bus.WR_URGENT    = wr_urgent;
  assign bus.RD_DATA      = rd_data_q;
  assign bus.RD_VALID     = rd_valid_q;
  assign bus.MEM_ADDR     = mem_addr_q;
  assign bus.MEM_WDATA    = mem_wdata_q;
  assign bus.MEM_CE_N     = ce_n_q;
  assign bus.MEM_OE_N     = oe_n_q;
  assign bus.MEM_WE_N     = we_n_q;
  assign bus.DBG_LAST_OP  = last_op_q;
  assign bus.DBG_WAIT_CNT = wait_cnt_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus randomized requester
// traffic, all checked every cycle against a cycle-level model of the
// arbitration rules and a queue of expected read data.
module tb_vga_fb_arbiter;
  localparam int ADDR_W      = 18;
  localparam int DATA_W      = 16;
  localparam int WR_MAX_WAIT = 8;
  localparam int CNT_W       = $clog2(WR_MAX_WAIT + 1);

  logic CLK;
  logic NRST;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_MAX_WAIT(WR_MAX_WAIT)) bus ();

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_MAX_WAIT(WR_MAX_WAIT)) dut (
    .CLK  (CLK),
    .NRST (NRST),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: bus direction (0 idle, 1 read, 2 write) and refusal count
  int                m_dir;
  int                m_refused;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ce, m_oe, m_we;
  logic [DATA_W-1:0] exp_q[$];
  logic              rd_done, wr_done;

  // what the DUT showed in the most recent step
  logic              obs_rd_ack, obs_wr_ack, obs_urgent, obs_rd_valid;
  logic [DATA_W-1:0] obs_rd_data, obs_wdata;
  logic [ADDR_W-1:0] obs_addr;
  logic              obs_ce, obs_oe, obs_we;
  logic [CNT_W-1:0]  obs_wait;

  // clock / reset block
  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  function automatic int obs_bus();
    if (obs_ce) return 0;
    if (!obs_oe) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_dir = 0; m_refused = 0; m_addr = '0; m_wdata = '0;
    m_ce = 1'b1; m_oe = 1'b1; m_we = 1'b1;
    exp_q.delete();
    rd_done = 1'b0; wr_done = 1'b0;
  endtask

  // hold reset for n cycles, checking reset values each cycle
  task automatic do_reset(input int n);
    NRST = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.RD_ACK !== 1'b0 || bus.WR_ACK !== 1'b0) begin
        errors++; $display("FAIL reset_ack: got rd=%b wr=%b expected 0 0", bus.RD_ACK, bus.WR_ACK);
      end
      checks++;
      if ({bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_WE_N} !== 3'b111) begin
        errors++; $display("FAIL reset_ctl: got %b expected 111", {bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_WE_N});
      end
      checks++;
      if (bus.RD_VALID !== 1'b0) begin
        errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.RD_VALID);
      end
      checks++;
      if (bus.MEM_ADDR !== '0 || bus.MEM_WDATA !== '0 || bus.RD_DATA !== '0 || bus.DBG_WAIT_CNT !== '0) begin
        errors++; $display("FAIL reset_regs: got addr=%h wdata=%h rdata=%h wait=%0d expected all 0",
                           bus.MEM_ADDR, bus.MEM_WDATA, bus.RD_DATA, bus.DBG_WAIT_CNT);
      end
      @(posedge CLK); #1;
    end
    NRST = 1'b1;
  endtask

  // one clock cycle: check DUT against the model at the negedge, then advance the model
  task automatic step();
    int   cand;
    logic e_rd, e_wr, e_valid;
    @(negedge CLK);
    cand = 0;
    if (m_refused == WR_MAX_WAIT && bus.WR_REQ) cand = 2;
    else if (bus.RD_REQ) cand = 1;
    else if (bus.WR_REQ) cand = 2;
    e_rd = (cand == 1) && (m_dir == 0 || m_dir == 1);
    e_wr = (cand == 2) && (m_dir == 0 || m_dir == 2);
    e_valid = (exp_q.size() != 0);

    checks++;
    if (bus.RD_ACK !== e_rd) begin
      errors++; $display("FAIL rd_ack @%0t: got %b expected %b", $time, bus.RD_ACK, e_rd);
    end
    checks++;
    if (bus.WR_ACK !== e_wr) begin
      errors++; $display("FAIL wr_ack @%0t: got %b expected %b", $time, bus.WR_ACK, e_wr);
    end
    checks++;
    if (bus.WR_URGENT !== (m_refused == WR_MAX_WAIT)) begin
      errors++; $display("FAIL wr_urgent @%0t: got %b expected %b", $time, bus.WR_URGENT, m_refused == WR_MAX_WAIT);
    end
    checks++;
    if ({bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_WE_N} !== {m_ce, m_oe, m_we}) begin
      errors++; $display("FAIL mem_ctl @%0t: got %b expected %b", $time,
                         {bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_WE_N}, {m_ce, m_oe, m_we});
    end
    checks++;
    if (bus.MEM_ADDR !== m_addr) begin
      errors++; $display("FAIL mem_addr @%0t: got %h expected %h", $time, bus.MEM_ADDR, m_addr);
    end
    checks++;
    if (bus.MEM_WDATA !== m_wdata) begin
      errors++; $display("FAIL mem_wdata @%0t: got %h expected %h", $time, bus.MEM_WDATA, m_wdata);
    end
    checks++;
    if (!bus.MEM_CE_N && !bus.MEM_OE_N && !bus.MEM_WE_N) begin
      errors++; $display("FAIL bus_collision @%0t: got OE_N=0 WE_N=0 expected not both", $time);
    end
    checks++;
    if (bus.RD_VALID !== e_valid) begin
      errors++; $display("FAIL rd_valid @%0t: got %b expected %b", $time, bus.RD_VALID, e_valid);
    end
    if (e_valid) begin
      logic [DATA_W-1:0] exp_d;
      exp_d = exp_q.pop_front();
      checks++;
      if (bus.RD_DATA !== exp_d) begin
        errors++; $display("FAIL rd_data @%0t: got %h expected %h", $time, bus.RD_DATA, exp_d);
      end
    end
    checks++;
    if (bus.DBG_LAST_OP !== 2'(m_dir) || bus.DBG_WAIT_CNT !== CNT_W'(m_refused)) begin
      errors++; $display("FAIL debug_state @%0t: got op=%0d wait=%0d expected op=%0d wait=%0d",
                         $time, bus.DBG_LAST_OP, bus.DBG_WAIT_CNT, m_dir, m_refused);
    end

    obs_rd_ack = bus.RD_ACK; obs_wr_ack = bus.WR_ACK; obs_urgent = bus.WR_URGENT;
    obs_rd_valid = bus.RD_VALID; obs_rd_data = bus.RD_DATA; obs_wdata = bus.MEM_WDATA;
    obs_addr = bus.MEM_ADDR; obs_ce = bus.MEM_CE_N; obs_oe = bus.MEM_OE_N; obs_we = bus.MEM_WE_N;
    obs_wait = bus.DBG_WAIT_CNT;

    // SRAM is being read this cycle: its data must come back out next cycle
    if (m_dir == 1) exp_q.push_back(bus.MEM_RDATA);
    if (e_rd) begin
      m_dir = 1; m_ce = 1'b0; m_oe = 1'b0; m_we = 1'b1; m_addr = bus.RD_ADDR;
    end else if (e_wr) begin
      m_dir = 2; m_ce = 1'b0; m_oe = 1'b1; m_we = 1'b0; m_addr = bus.WR_ADDR; m_wdata = bus.WR_DATA;
    end else begin
      m_dir = 0; m_ce = 1'b1; m_oe = 1'b1; m_we = 1'b1;
    end
    if (!bus.WR_REQ || e_wr) m_refused = 0;
    else if (m_refused < WR_MAX_WAIT) m_refused++;
    rd_done = e_rd; wr_done = e_wr;
    @(posedge CLK); #1;
  endtask

  // driver: random requesters that respect the hold-until-transfer rule
  task automatic drive_random(input int rd_pct, input int wr_pct);
    if (!bus.RD_REQ || rd_done) begin
      bus.RD_REQ  = ($urandom_range(0, 99) < rd_pct);
      bus.RD_ADDR = ADDR_W'($urandom);
    end
    if (!bus.WR_REQ || wr_done) begin
      bus.WR_REQ  = ($urandom_range(0, 99) < wr_pct);
      bus.WR_ADDR = ADDR_W'($urandom);
      bus.WR_DATA = DATA_W'($urandom);
    end
    bus.MEM_RDATA = DATA_W'($urandom);
  endtask

  task automatic idle_inputs();
    bus.RD_REQ = 1'b0; bus.WR_REQ = 1'b0;
    bus.RD_ADDR = '0; bus.WR_ADDR = '0; bus.WR_DATA = '0; bus.MEM_RDATA = '0;
  endtask

  task automatic test_reset();
    bus.RD_REQ = 1'b1; bus.WR_REQ = 1'b1; bus.RD_ADDR = 18'h00555; bus.WR_ADDR = 18'h00AAA;
    do_reset(2);
    step();
    checks++;
    if (obs_rd_ack !== 1'b1 || obs_wr_ack !== 1'b0) begin
      errors++; $display("FAIL reset_first_grant: got rd=%b wr=%b expected 1 0", obs_rd_ack, obs_wr_ack);
    end
    idle_inputs();
    do_reset(1);
  endtask

  task automatic test_single_read();
    bus.RD_REQ = 1'b1; bus.RD_ADDR = 18'h00123; bus.MEM_RDATA = 16'hBEEF;
    step();
    checks++;
    if (obs_rd_ack !== 1'b1) begin
      errors++; $display("FAIL single_read_ack: got %b expected 1", obs_rd_ack);
    end
    bus.RD_REQ = 1'b0;
    step();
    checks++;
    if (obs_addr !== 18'h00123 || obs_ce !== 1'b0 || obs_oe !== 1'b0 || obs_rd_valid !== 1'b0) begin
      errors++; $display("FAIL single_read_bus: got addr=%h ce=%b oe=%b valid=%b expected 00123 0 0 0",
                         obs_addr, obs_ce, obs_oe, obs_rd_valid);
    end
    bus.MEM_RDATA = 16'h0000;
    step();
    checks++;
    if (obs_rd_valid !== 1'b1 || obs_rd_data !== 16'hBEEF) begin
      errors++; $display("FAIL single_read_data: got valid=%b data=%h expected 1 beef", obs_rd_valid, obs_rd_data);
    end
    step();
  endtask

  task automatic test_burst();
    int rd_n, wr_n;
    int exp_pat[9];
    int got_pat[9];
    exp_pat = '{0, 1, 1, 1, 1, 0, 2, 2, 0};
    rd_n = 0; wr_n = 0;
    do_reset(1);
    bus.RD_REQ = 1'b1; bus.RD_ADDR = 18'h10;
    bus.WR_REQ = 1'b1; bus.WR_ADDR = 18'h20; bus.WR_DATA = 16'h1111;
    for (int i = 0; i < 9; i++) begin
      bus.MEM_RDATA = DATA_W'($urandom);
      step();
      got_pat[i] = obs_bus();
      if (got_pat[i] == 2) begin
        checks++;
        if (obs_wdata !== ((i == 6) ? 16'h1111 : 16'h2222)) begin
          errors++; $display("FAIL burst_wdata step %0d: got %h expected %h", i, obs_wdata,
                             (i == 6) ? 16'h1111 : 16'h2222);
        end
      end
      if (rd_done) begin
        rd_n++;
        bus.RD_ADDR = bus.RD_ADDR + 1'b1;
        if (rd_n == 4) bus.RD_REQ = 1'b0;
      end
      if (wr_done) begin
        wr_n++;
        bus.WR_ADDR = 18'h21; bus.WR_DATA = 16'h2222;
        if (wr_n == 2) bus.WR_REQ = 1'b0;
      end
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got_pat[i] !== exp_pat[i]) begin
        errors++; $display("FAIL burst_pattern step %0d: got %0d expected %0d", i, got_pat[i], exp_pat[i]);
      end
    end
  endtask

  task automatic test_starvation();
    int first_urgent, wr_step;
    int got_pat[14];
    first_urgent = -1; wr_step = -1;
    do_reset(1);
    bus.RD_REQ = 1'b1; bus.RD_ADDR = ADDR_W'($urandom);
    bus.WR_REQ = 1'b1; bus.WR_ADDR = 18'h3FFFF; bus.WR_DATA = 16'h5A5A;
    for (int i = 0; i < 14; i++) begin
      bus.MEM_RDATA = DATA_W'($urandom);
      step();
      got_pat[i] = obs_bus();
      if (obs_urgent && first_urgent < 0) first_urgent = i;
      if (obs_wr_ack) wr_step = i;
      if (i == 11) begin
        checks++;
        if (obs_wait !== '0) begin
          errors++; $display("FAIL starve_wait_clear: got %0d expected 0", obs_wait);
        end
      end
      if (rd_done) bus.RD_ADDR = ADDR_W'($urandom);
      if (wr_done) bus.WR_REQ = 1'b0;
    end
    bus.RD_REQ = 1'b0;
    checks++;
    if (first_urgent !== 8) begin
      errors++; $display("FAIL starve_urgent_step: got %0d expected 8", first_urgent);
    end
    checks++;
    if (wr_step !== 9) begin
      errors++; $display("FAIL starve_write_step: got %0d expected 9", wr_step);
    end
    checks++;
    if (got_pat[8] !== 1 || got_pat[9] !== 0 || got_pat[10] !== 2 || got_pat[11] !== 0 || got_pat[12] !== 1) begin
      errors++; $display("FAIL starve_pattern: got %0d%0d%0d%0d%0d expected 10201",
                         got_pat[8], got_pat[9], got_pat[10], got_pat[11], got_pat[12]);
    end
    step();
    step();
  endtask

  task automatic test_simultaneous();
    int rd_step, wr_step;
    rd_step = -1; wr_step = -1;
    do_reset(1);
    bus.RD_REQ = 1'b1; bus.RD_ADDR = 18'h00777;
    bus.WR_REQ = 1'b1; bus.WR_ADDR = 18'h00888; bus.WR_DATA = 16'hC0DE;
    for (int i = 0; i < 6; i++) begin
      bus.MEM_RDATA = DATA_W'($urandom);
      step();
      if (obs_rd_ack) rd_step = i;
      if (obs_wr_ack) wr_step = i;
      if (rd_done) bus.RD_REQ = 1'b0;
      if (wr_done) bus.WR_REQ = 1'b0;
    end
    checks++;
    if (rd_step !== 0 || wr_step !== 2) begin
      errors++; $display("FAIL simultaneous_order: got rd=%0d wr=%0d expected 0 2", rd_step, wr_step);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset(1);
    bus.RD_REQ = 1'b1; bus.RD_ADDR = 18'h01234; bus.MEM_RDATA = 16'h1357;
    step();
    bus.RD_REQ = 1'b0;
    do_reset(2);
    step();
    checks++;
    if (obs_rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_read_valid: got %b expected 0", obs_rd_valid);
    end
    step();
  endtask

  task automatic test_random();
    int rd_pct[4];
    int wr_pct[4];
    rd_pct = '{30, 90, 100, 60};
    wr_pct = '{30, 40, 70, 90};
    do_reset(1);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 300; c++) begin
        drive_random(rd_pct[p], wr_pct[p]);
        step();
      end
    end
    idle_inputs();
    step();
    step();
  endtask

  initial begin
    NRST = 1'b1;
    idle_inputs();
    model_reset();
    #5;
    test_reset();
    test_single_read();
    test_burst();
    test_starvation();
    test_simultaneous();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Single-port frame-buffer SRAM arbiter for the video path. Shares one external SRAM between the VGA display reader (priority, latency-critical) and the video-input writer. Guarantees bounded write wait and inserts a bus-turnaround bubble on every read/write direction change. Sits between the pixel pipeline and the SRAM pads in the fpga top level, clocked at 50 MHz.

Parameters:
ADDR_W, 18, SRAM word address width
DATA_W, 16, SRAM data width
WR_MAX_WAIT, 8, max cycles a pending write may be refused before it becomes urgent (>=1)

Ports:
CLK  input  1  system clock (50 MHz)
NRST  input  1  asynchronous active-low reset
RD_REQ  input  1  display read request
RD_ADDR  input  ADDR_W  read address, valid with RD_REQ
RD_ACK  output  1  read accepted; transfer on rising edge where RD_REQ&RD_ACK
RD_DATA  output  DATA_W  read data
RD_VALID  output  1  RD_DATA valid, one-cycle pulse per accepted read
WR_REQ  input  1  video-input write request
WR_ADDR  input  ADDR_W  write address, valid with WR_REQ
WR_DATA  input  DATA_W  write data, valid with WR_REQ
WR_ACK  output  1  write accepted; transfer on rising edge where WR_REQ&WR_ACK
WR_URGENT  output  1  write wait counter saturated
MEM_ADDR  output  ADDR_W  SRAM address (registered)
MEM_WDATA  output  DATA_W  SRAM write data (registered)
MEM_RDATA  input  DATA_W  SRAM read data
MEM_CE_N  output  1  SRAM chip enable, active low (registered)
MEM_OE_N  output  1  SRAM output enable, active low (registered)
MEM_WE_N  output  1  SRAM write enable, active low (registered)

Behaviour:
- Reset (NRST=0, async): MEM_CE_N/OE_N/WE_N=1, MEM_ADDR=0, MEM_WDATA=0, RD_DATA=0, RD_VALID=0, last_op=NONE, wait_cnt=0. RD_ACK/WR_ACK forced 0 while NRST=0. Reset mid-access discards any pending RD_VALID.
- Requester rule: REQ, ADDR, DATA held stable until the transfer edge; REQ may drop or change only after it.
- last_op register ∈ {NONE, RD, WR} = direction of the access driven on the bus in the current cycle.
- Candidate selection (combinational, each cycle): WR_URGENT&WR_REQ → WR; else RD_REQ → RD; else WR_REQ → WR; else none.
- Grant: ACK asserted for the candidate only if last_op is NONE or equals the candidate direction. Otherwise no ACK (bubble): next bus cycle idle, last_op→NONE, candidate granted the following cycle if still selected.
- At the transfer edge T: MEM_* registered for cycle T+1. Read: CE_N=0, OE_N=0, WE_N=1, MEM_ADDR=RD_ADDR. Write: CE_N=0, OE_N=1, WE_N=0, MEM_ADDR=WR_ADDR, MEM_WDATA=WR_DATA. last_op←RD/WR.
- No transfer at edge T: CE_N/OE_N/WE_N=1 in T+1, MEM_ADDR/MEM_WDATA hold, last_op←NONE.
- Read data: MEM_RDATA sampled at end of cycle T+1 into RD_DATA; RD_VALID=1 during T+2. Latency 2 edges from transfer. Back-to-back reads: 1 per cycle.
- Back-to-back writes: 1 per cycle. Direction change costs exactly one idle cycle.
- wait_cnt: +1 on each edge with WR_REQ=1 and no write transfer, saturating at WR_MAX_WAIT. Clears on write transfer or WR_REQ=0. WR_URGENT = (wait_cnt==WR_MAX_WAIT).
- Urgent write while bus reading: bubble, then write, regardless of RD_REQ. After one write, counter clears and reads regain priority (bubble, then read).
- Simultaneous RD_REQ and WR_REQ, not urgent, last_op=NONE: read granted.

Test Plan:
- Reset: NRST=0 for 2 cycles with RD_REQ=WR_REQ=1 → all ACK=0, MEM_*_N=1, RD_VALID=0; after release, read granted first cycle.
- Single read: RD_REQ, RD_ADDR=0x00123, MEM_RDATA=0xBEEF → RD_ACK same cycle; next cycle MEM_ADDR=0x00123, CE_N=OE_N=0; RD_VALID=1 with RD_DATA=0xBEEF two edges after transfer.
- Burst: 4 reads at 0x10–0x13 then 2 writes at 0x20/0x21 (data 0x1111/0x2222) → 4 consecutive read cycles, 1 idle cycle, 2 write cycles with WE_N=0, correct MEM_WDATA.
- Starvation: RD_REQ held high, WR_REQ=1 at 0x3FFFF, WR_MAX_WAIT=8 → WR_URGENT after 8 refused cycles; one bubble; write occurs; wait_cnt=0; reads resume after one bubble.
- Simultaneous requests from idle, not urgent → read first, bubble, then write; no cycle with CE_N=0 and both OE_N=0 and WE_N=0.
- Reset mid-read: NRST low one cycle after read transfer → no RD_VALID pulse; outputs at reset values.
